noise_cfg_spi_tx: RTL and testbench

//  SPI transmit end of the noise generator config link: serialises one 40-bit frame
//  {freq_div[16:0], lfsr_seed[22:0]} MSB first onto spi_clock/spi_data/spi_cs.

---
 rtl/noise_cfg_spi_tx_pkg.sv | 41 ++++
 rtl/noise_cfg_spi_tx_if.sv | 27 ++
 rtl/noise_cfg_spi_tx_phase_timer.sv | 36 +++
 rtl/noise_cfg_spi_tx.sv | 152 +++++++++++++++
 tb/tb_noise_cfg_spi_tx.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_cfg_spi_tx_pkg.sv
// Shared definitions for the noise generator config link: frame layout, seed guard, FSM states.
// No logic; imported by the SPI transmitter and its interface.
// Frame field positions must match the noise_gen receiver.
package noise_cfg_spi_tx_pkg;

    localparam int FRAME_BITS = 40;
    localparam int FDIV_MSB   = 39;
    localparam int FDIV_LSB   = 23;
    localparam int SEED_MSB   = 22;
    localparam int SEED_LSB   = 0;
    localparam int FDIV_W     = FDIV_MSB - FDIV_LSB + 1;
    localparam int SEED_W     = SEED_MSB - SEED_LSB + 1;
    localparam int BIT_CNT_W  = 6;

    localparam logic [SEED_W-1:0] SEED_DEFAULT_VAL = 23'd111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_e;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // An all-zero seed would lock the receiver's LFSR, so it is replaced.
    function automatic logic [SEED_W-1:0] seed_guard(input logic [SEED_W-1:0] seed,
                                                     input logic [SEED_W-1:0] dflt);
        return (seed == '0) ? dflt : seed;
    endfunction

endpackage

// File: rtl/noise_cfg_spi_tx_if.sv
// Config request handshake plus SPI pins between the command decoder and the SPI transmitter.
// Pure wiring, zero latency.
// Backpressure: cfg_ready from the transmitter gates cfg_valid.
interface noise_cfg_spi_tx_if;
    import noise_cfg_spi_tx_pkg::*;

    logic              cfg_valid;
    logic              cfg_ready;
    logic [FDIV_W-1:0] cfg_freq_div;
    logic [SEED_W-1:0] cfg_seed;
    logic              busy;
    logic              done;
    logic              spi_clock;
    logic              spi_data;
    logic              spi_cs;

    modport master (
        output cfg_valid, cfg_freq_div, cfg_seed,
        input  cfg_ready, busy, done, spi_clock, spi_data, spi_cs
    );

    modport slave (
        input  cfg_valid, cfg_freq_div, cfg_seed,
        output cfg_ready, busy, done, spi_clock, spi_data, spi_cs
    );

endinterface

// File: rtl/noise_cfg_spi_tx_phase_timer.sv
// Down-counter timing every FSM phase: load N-1 on phase entry, expire_o high while count is 0.
// Expire is a registered compare, valid the cycle after load.
// No backpressure; load_i always wins over the decrement.
module noise_cfg_spi_tx_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/noise_cfg_spi_tx.sv
// Serialises one 40-bit {freq_div, seed} frame MSB first over spi_clock/spi_data/spi_cs.
// Frame takes 2*CLK_DIV*40 + CS_SETUP + CS_HOLD + CS_GAP + 1 cycles from accept to cfg_ready.
// Backpressure: cfg_ready low for the whole frame; requests while busy are dropped, not queued.
module noise_cfg_spi_tx
    import noise_cfg_spi_tx_pkg::*;
#(
    parameter int                CLK_DIV      = 4,
    parameter int                CS_SETUP     = 2,
    parameter int                CS_HOLD      = 2,
    parameter int                CS_GAP       = 4,
    parameter logic [SEED_W-1:0] SEED_DEFAULT = SEED_DEFAULT_VAL
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    noise_cfg_spi_tx_if.slave  cfg
);

    localparam int PH_MAX = max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_GAP);
    localparam int PH_W   = $clog2(PH_MAX + 1);

    state_e                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shift_q, shift_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                    cs_q, cs_d;
    logic                    sclk_q, sclk_d;
    logic                    sdat_q, sdat_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    logic                    ready;
    logic                    accept;
    logic                    tmr_load;
    logic [PH_W-1:0]         tmr_val;
    logic                    tmr_expire;

    assign ready  = (state_q == ST_IDLE) & ~sys_rst;
    assign accept = cfg.cfg_valid & ready;

    noise_cfg_spi_tx_phase_timer #(
        .W (PH_W)
    ) u_phase_timer (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d                    = ST_SETUP;
                    shift_d[FDIV_MSB:FDIV_LSB] = cfg.cfg_freq_div;
                    shift_d[SEED_MSB:SEED_LSB] = seed_guard(cfg.cfg_seed, SEED_DEFAULT);
                    bit_cnt_d                  = BIT_CNT_W'(FRAME_BITS - 1);
                    tmr_load                   = 1'b1;
                    tmr_val                    = PH_W'(CS_SETUP - 1);
                end
            end
            ST_SETUP: begin
                if (tmr_expire) begin
                    state_d  = ST_HIGH;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(CLK_DIV - 1);
                end
            end
            ST_HIGH: begin
                if (tmr_expire) begin
                    state_d  = ST_LOW;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(CLK_DIV - 1);
                end
            end
            ST_LOW: begin
                // Data advances only here, a full half-period after the receiver sampled it.
                if (tmr_expire) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q == '0) begin
                        state_d = ST_HOLD;
                        tmr_val = PH_W'(CS_HOLD - 1);
                    end else begin
                        state_d   = ST_HIGH;
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                        tmr_val   = PH_W'(CLK_DIV - 1);
                    end
                end
            end
            ST_HOLD: begin
                if (tmr_expire) begin
                    state_d  = ST_GAP;
                    done_d   = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = PH_W'(CS_GAP - 1);
                end
            end
            ST_GAP: begin
                if (tmr_expire) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pin values are derived from the next state so every output leaves a flop.
        cs_d   = ~((state_d == ST_SETUP) || (state_d == ST_HIGH) ||
                   (state_d == ST_LOW)   || (state_d == ST_HOLD));
        sclk_d = (state_d == ST_HIGH);
        sdat_d = cs_d ? 1'b0 : shift_d[FRAME_BITS-1];
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            cs_q      <= 1'b1;
            sclk_q    <= 1'b0;
            sdat_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            cs_q      <= cs_d;
            sclk_q    <= sclk_d;
            sdat_q    <= sdat_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
        end
    end

    assign cfg.cfg_ready = ready;
    assign cfg.busy      = busy_q;
    assign cfg.done      = done_q;
    assign cfg.spi_clock = sclk_q;
    assign cfg.spi_data  = sdat_q;
    assign cfg.spi_cs    = cs_q;

endmodule

// File: tb/tb_noise_cfg_spi_tx.sv
// Random config frames into two transmitter instances (default and fastest timing),
// compared against an SPI receiver model and frame timing computed from the parameters.
module tb_noise_cfg_spi_tx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    noise_cfg_spi_tx_if a_if ();
    noise_cfg_spi_tx_if b_if ();

    logic        sel;
    logic        tb_valid;
    logic [16:0] tb_freq;
    logic [22:0] tb_seed;

    assign a_if.cfg_valid    = tb_valid & ~sel;
    assign a_if.cfg_freq_div = tb_freq;
    assign a_if.cfg_seed     = tb_seed;
    assign b_if.cfg_valid    = tb_valid & sel;
    assign b_if.cfg_freq_div = tb_freq;
    assign b_if.cfg_seed     = tb_seed;

    noise_cfg_spi_tx u_dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .cfg     (a_if.slave)
    );

    noise_cfg_spi_tx #(
        .CLK_DIV  (1),
        .CS_SETUP (1),
        .CS_HOLD  (1),
        .CS_GAP   (1)
    ) u_fast (
        .sys_clk (clk),
        .sys_rst (rst),
        .cfg     (b_if.slave)
    );

    wire m_cs   = sel ? b_if.spi_cs    : a_if.spi_cs;
    wire m_clk  = sel ? b_if.spi_clock : a_if.spi_clock;
    wire m_dat  = sel ? b_if.spi_data  : a_if.spi_data;
    wire m_done = sel ? b_if.done      : a_if.done;
    wire m_rdy  = sel ? b_if.cfg_ready : a_if.cfg_ready;
    wire m_busy = sel ? b_if.busy      : a_if.busy;

    // Timing of the selected instance
    int cd = 4, su = 2, ho = 2, ga = 4;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] ref_word(input logic [16:0] f, input logic [22:0] s);
        logic [22:0] seed_eff;
        seed_eff = (s == 23'd0) ? 23'd111 : s;
        return {f, seed_eff};
    endfunction

    function automatic int frame_len();
        return 2 * cd * 40 + su + ho + ga + 1;
    endfunction

    function automatic int exp_rise(input int acc);
        return acc + su + 2 * cd * 40 + ho + 1;
    endfunction

    // SPI receiver model plus event log, sampled on the sys_clk falling edge
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          cs_fall_q[$], cs_rise_q[$], fall_q[$], done_q[$], rdy_q[$], nfall_q[$];
    logic [39:0] word_q[$];
    int          stab_err = 0, csdat_err = 0, rb_err = 0;
    logic [39:0] cap = '0;
    int          nfall = 0;
    logic        p_cs = 1'b1, p_clk = 1'b0, p_dat = 1'b0, p_rdy = 1'b0;

    always @(negedge clk) begin
        if (!m_cs && p_cs) begin
            cap = '0;
            nfall = 0;
            cs_fall_q.push_back(cyc);
        end
        if (p_clk && !m_clk && !m_cs) begin
            cap = {cap[38:0], m_dat};
            nfall++;
            fall_q.push_back(cyc);
            if (m_dat !== p_dat) stab_err++;
        end
        if (m_cs && !p_cs) begin
            word_q.push_back(cap);
            nfall_q.push_back(nfall);
            cs_rise_q.push_back(cyc);
        end
        if (m_cs && m_dat) csdat_err++;
        if (m_rdy && m_busy) rb_err++;
        if (m_done) done_q.push_back(cyc);
        if (m_rdy && !p_rdy) rdy_q.push_back(cyc);
        p_cs  = m_cs;
        p_clk = m_clk;
        p_dat = m_dat;
        p_rdy = m_rdy;
    end

    task automatic clr();
        cs_fall_q.delete(); cs_rise_q.delete(); fall_q.delete();
        done_q.delete(); rdy_q.delete(); nfall_q.delete(); word_q.delete();
        stab_err = 0; csdat_err = 0; rb_err = 0;
    endtask

    task automatic wait_accept(output int acc);
        bit ok;
        ok  = 1'b0;
        acc = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (m_rdy && tb_valid) begin
                acc = cyc;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 64'(0), 64'(1));
    endtask

    task automatic frame_checks(input string tag, input int acc, input int idx, input logic [39:0] exp_w);
        if (word_q.size() > idx) begin
            chk({tag, "_word"}, 64'(word_q[idx]), 64'(exp_w));
            chk({tag, "_nfall"}, 64'(nfall_q[idx]), 64'(40));
            chk({tag, "_cs_rise"}, 64'(cs_rise_q[idx]), 64'(exp_rise(acc)));
        end else begin
            chk({tag, "_frames"}, 64'(word_q.size()), 64'(idx + 1));
        end
        if (cs_fall_q.size() > idx)
            chk({tag, "_cs_fall"}, 64'(cs_fall_q[idx]), 64'(acc + 1));
        if (fall_q.size() >= 40 * (idx + 1)) begin
            chk({tag, "_fall0"}, 64'(fall_q[40 * idx]), 64'(acc + su + cd + 1));
            chk({tag, "_fall39"}, 64'(fall_q[40 * idx + 39]), 64'(acc + su + cd + 1 + 2 * cd * 39));
        end else begin
            chk({tag, "_falls"}, 64'(fall_q.size()), 64'(40 * (idx + 1)));
        end
    endtask

    task automatic run_frame(input string tag, input logic [16:0] f, input logic [22:0] s, input bit scramble);
        int acc;
        @(posedge clk); #1;
        clr();
        tb_freq  = f;
        tb_seed  = s;
        tb_valid = 1'b1;
        wait_accept(acc);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        if (scramble) begin
            tb_freq = 17'($urandom);
            tb_seed = 23'($urandom);
            repeat (cd * 20) @(posedge clk);
            #1;
            tb_freq  = ~f;
            tb_seed  = 23'($urandom);
            tb_valid = 1'b1;  // dropped while busy
            repeat (5) @(posedge clk);
            #1;
            tb_valid = 1'b0;
        end
        repeat (frame_len() + 2) @(negedge clk);
        frame_checks(tag, acc, 0, ref_word(f, s));
        chk({tag, "_ndone"}, 64'(done_q.size()), 64'(1));
        if (done_q.size() > 0) chk({tag, "_done_cyc"}, 64'(done_q[0]), 64'(exp_rise(acc)));
        if (rdy_q.size() > 0) chk({tag, "_ready_cyc"}, 64'(rdy_q[0]), 64'(acc + frame_len()));
        else chk({tag, "_ready_back"}, 64'(0), 64'(1));
        chk({tag, "_stab"}, 64'(stab_err), 64'(0));
        chk({tag, "_csdat"}, 64'(csdat_err), 64'(0));
        chk({tag, "_rdybusy"}, 64'(rb_err), 64'(0));
    endtask

    task automatic run_b2b();
        int          acc[3];
        logic [39:0] exp_w[3];
        @(posedge clk); #1;
        clr();
        tb_valid = 1'b1;
        tb_freq  = 17'($urandom);
        tb_seed  = 23'($urandom);
        for (int f = 0; f < 3; f++) begin
            wait_accept(acc[f]);
            exp_w[f] = ref_word(tb_freq, tb_seed);
            @(posedge clk); #1;
            tb_freq = 17'($urandom);
            tb_seed = 23'($urandom);
            if (f == 2) tb_valid = 1'b0;
        end
        repeat (frame_len() + 2) @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            frame_checks($sformatf("b2b%0d", f), acc[f], f, exp_w[f]);
        end
        for (int f = 0; f < 2; f++) begin
            chk("b2b_period", 64'(acc[f + 1] - acc[f]), 64'(frame_len()));
            if (cs_fall_q.size() > f + 1 && cs_rise_q.size() > f)
                chk("b2b_cs_gap", 64'(cs_fall_q[f + 1] - cs_rise_q[f]), 64'(ga + 1));
        end
        chk("b2b_ndone", 64'(done_q.size()), 64'(3));
        chk("b2b_rdybusy", 64'(rb_err), 64'(0));
    endtask

    task automatic run_reset_abort();
        int acc;
        @(posedge clk); #1;
        clr();
        tb_freq  = 17'($urandom);
        tb_seed  = 23'($urandom);
        tb_valid = 1'b1;
        wait_accept(acc);
        @(posedge clk); #1;
        tb_valid = 1'b0;
        for (int i = 0; i < 400 && cyc != acc + 150; i++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ready_low", 64'(m_rdy), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_cs", 64'(m_cs), 64'(1));
        chk("abort_clk", 64'(m_clk), 64'(0));
        chk("abort_dat", 64'(m_dat), 64'(0));
        chk("abort_ready", 64'(m_rdy), 64'(1));
        chk("abort_busy", 64'(m_busy), 64'(0));
        repeat (20) @(negedge clk);
        chk("abort_ndone", 64'(done_q.size()), 64'(0));
        run_frame("after_rst", 17'($urandom), 23'($urandom), 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        sel      = 1'b0;
        tb_valid = 1'b0;
        tb_freq  = '0;
        tb_seed  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", 64'(m_cs), 64'(1));
        chk("rst_clk", 64'(m_clk), 64'(0));
        chk("rst_dat", 64'(m_dat), 64'(0));
        chk("rst_ready", 64'(m_rdy), 64'(0));
        chk("rst_busy", 64'(m_busy), 64'(0));
        chk("rst_done", 64'(m_done), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 64'(m_rdy), 64'(1));

        run_frame("t1", 17'h1ABCD, 23'h2A5A5A, 1'b0);
        run_frame("zero_seed", 17'd13000, 23'd0, 1'b0);
        run_b2b();
        run_reset_abort();
        run_frame("midchange", 17'($urandom), 23'($urandom), 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_frame($sformatf("rnd%0d", i), 17'($urandom),
                      ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom), 1'b0);
        end

        @(posedge clk); #1;
        sel = 1'b1;
        cd = 1; su = 1; ho = 1; ga = 1;
        for (int i = 0; i < 5; i++) begin
            run_frame($sformatf("fast%0d", i), 17'($urandom),
                      (i == 2) ? 23'd0 : 23'($urandom), i == 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
